// File: rtl/mips_fetch.sv
// MIPS instruction fetch stage: request/hold/halt sequencing and
// next-PC selection (jump, register jump, branch, fall-through).
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        jr,
  input  logic        branch,
  input  logic        br_taken,
  input  logic [31:0] rs_data,
  input  logic        halt,
  output logic        halted,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        aerr_q, aerr_d;

  logic        accept;
  logic        misalign;
  logic [31:0] br_off;
  logic [31:0] npc;

  assign accept   = (state_q == S_HOLD) && inst_ready;
  assign misalign = jr && (rs_data[1:0] != 2'b00);
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    if (jr)
      npc = rs_data;
    else if (jump)
      npc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    else if (branch && br_taken)
      npc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_FETCH;
      fpc_q   <= RESET_PC;
      inst_q  <= '0;
      pc_q    <= RESET_PC;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      aerr_q  <= aerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (imem_ack) state_d = S_HOLD;
      S_HOLD: begin
        if (accept) begin
          if (halt || misalign)
            state_d = S_HALT;
          else
            state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    fpc_d  = fpc_q;
    inst_d = inst_q;
    pc_d   = pc_q;
    aerr_d = aerr_q;
    if (state_q == S_FETCH && imem_ack) begin
      inst_d = imem_rdata;
      pc_d   = fpc_q;
    end
    // halt wins over any redirect, including a bad jr target
    if (accept && !halt) begin
      if (misalign)
        aerr_d = 1'b1;
      else
        fpc_d = npc;
    end
  end

  always_comb begin
    imem_req   = rst_b && (state_q == S_FETCH);
    imem_addr  = {fpc_q[31:2], 2'b00};
    inst       = inst_q;
    pc         = pc_q;
    inst_valid = (state_q == S_HOLD);
    halted     = (state_q == S_HALT);
    addr_err   = aerr_q;
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Randomized self-checking bench for mips_fetch with a
// behavioural next-PC model and directed boundary scenarios.
module tb_mips_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump, jr, branch, br_taken, halt;
  logic [31:0] rs_data;
  logic        halted;
  logic        addr_err;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  mips_fetch dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .jump       (jump),
    .jr         (jr),
    .branch     (branch),
    .br_taken   (br_taken),
    .rs_data    (rs_data),
    .halt       (halt),
    .halted     (halted),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Next fetch address as the ISA defines it; no delay slot.
  function automatic logic [31:0] model_npc(
    input logic [31:0] p, input logic [31:0] w,
    input bit j, input bit r, input bit b, input bit t,
    input logic [31:0] rs);
    logic [31:0] n;
    int off;
    n = p + 32'd4;
    if (r) return rs;
    if (j) return (n & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if (b && t) begin
      off = $signed(w[15:0]);
      return n + off * 4;
    end
    return n;
  endfunction

  task automatic do_fetch(input int dly, input logic [31:0] word,
                          output logic [31:0] addr, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      ok = 1'b0;
      addr = 'x;
      return;
    end
    addr = imem_addr;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== addr) ok = 1'b0;
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_accept(input bit j, input bit r, input bit b,
                           input bit t, input bit h,
                           input logic [31:0] rs);
    inst_ready = 1'b1;
    jump = j; jr = r; branch = b; br_taken = t; halt = h;
    rs_data = rs;
    @(negedge clk);
    inst_ready = 1'b0;
    {jump, jr, branch, br_taken, halt} = 5'($urandom);
    rs_data = $urandom;
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic go_to(input logic [31:0] tgt);
    logic [31:0] a;
    bit ok;
    do_fetch(0, $urandom, a, ok);
    do_accept(0, 1, 0, 0, 0, tgt);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    {jump, jr, branch, br_taken, halt} = '0;
    rs_data = '0;
    imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({imem_req, inst_valid, halted, addr_err} !== 4'b0000) begin
      $display("FAIL reset_flags: got req/val/hlt/err=%b want 0000",
               {imem_req, inst_valid, halted, addr_err});
    end else n_pass++;
    n_chk++;
    if (imem_addr !== RST_PC || pc !== RST_PC || inst !== 32'h0) begin
      $display("FAIL reset_regs: addr=%h pc=%h inst=%h want %h %h 0",
               imem_addr, pc, inst, RST_PC, RST_PC);
    end else n_pass++;
    rst_b = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      $display("FAIL reset_first_req: req=%b addr=%h want 1 %h",
               imem_req, imem_addr, RST_PC);
    end else n_pass++;
  endtask

  task automatic test_first_fetch();
    logic [31:0] a;
    bit ok;
    int c0;
    c0 = cyc;
    do_fetch(0, 32'h2008_0005, a, ok);
    n_chk++;
    if (!ok || a !== RST_PC) begin
      $display("FAIL first_addr: got %h want %h", a, RST_PC);
    end else n_pass++;
    n_chk++;
    if (inst_valid !== 1'b1 || inst !== 32'h2008_0005 ||
        pc !== RST_PC || pc_plus4 !== 32'h0040_0004) begin
      $display("FAIL first_hold: v=%b inst=%h pc=%h p4=%h",
               inst_valid, inst, pc, pc_plus4);
    end else n_pass++;
    do_accept(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 ||
        inst_valid !== 1'b0) begin
      $display("FAIL first_next: req=%b addr=%h v=%b want 1 00400004 0",
               imem_req, imem_addr, inst_valid);
    end else n_pass++;
    n_chk++;
    if (cyc - c0 !== 2) begin
      $display("FAIL throughput: got %0d cycles want 2", cyc - c0);
    end else n_pass++;
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit ok;
    go_to(32'h0040_0010);
    do_fetch(0, 32'h1022_FFFE, a, ok);
    n_chk++;
    if (!ok || pc !== 32'h0040_0010) begin
      $display("FAIL branch_pc: got %h want 00400010", pc);
    end else n_pass++;
    do_accept(0, 0, 1, 1, 0, 0);
    n_chk++;
    if (imem_addr !== 32'h0040_000C) begin
      $display("FAIL branch_taken: got %h want 0040000c", imem_addr);
    end else n_pass++;
    go_to(32'h0040_0010);
    do_fetch(1, 32'h1022_FFFE, a, ok);
    do_accept(0, 0, 1, 0, 0, 0);
    n_chk++;
    if (!ok || imem_addr !== 32'h0040_0014) begin
      $display("FAIL branch_not_taken: got %h want 00400014", imem_addr);
    end else n_pass++;
  endtask

  task automatic test_jump();
    logic [31:0] a;
    bit ok;
    go_to(RST_PC);
    do_fetch(0, 32'h0810_0008, a, ok);
    do_accept(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (!ok || imem_addr !== 32'h0040_0020) begin
      $display("FAIL jump: got %h want 00400020", imem_addr);
    end else n_pass++;
    go_to(RST_PC);
    do_fetch(0, 32'h0810_0008, a, ok);
    do_accept(1, 1, 1, 1, 0, 32'h0040_1000);
    n_chk++;
    if (!ok || imem_addr !== 32'h0040_1000) begin
      $display("FAIL jr_priority: got %h want 00401000", imem_addr);
    end else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic [31:0] exp_pc;
    bit ok;
    bit bad;
    exp_pc = imem_addr;
    do_fetch(3, 32'hDEAD_BEEC, a, ok);
    n_chk++;
    if (!ok || a !== exp_pc) begin
      $display("FAIL stall_addr_stable: got %h ok=%b want %h", a, ok, exp_pc);
    end else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {jump, jr, branch, br_taken, halt} = 5'($urandom);
      imem_ack = 1'($urandom);
      @(negedge clk);
      if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEC ||
          pc !== exp_pc || imem_req !== 1'b0) bad = 1'b1;
    end
    imem_ack = 1'b0;
    n_chk++;
    if (bad) begin
      $display("FAIL stall_hold: inst=%h pc=%h req=%b want deadbeec %h 0",
               inst, pc, imem_req, exp_pc);
    end else n_pass++;
    do_accept(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_addr !== exp_pc + 32'd4) begin
      $display("FAIL stall_next: got %h want %h", imem_addr, exp_pc + 4);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit ok;
    go_to(32'hFFFF_FFFC);
    do_fetch(0, 32'h0, a, ok);
    n_chk++;
    if (!ok || pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      $display("FAIL wrap_p4: pc=%h p4=%h want fffffffc 0", pc, pc_plus4);
    end else n_pass++;
    do_accept(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_addr !== 32'h0) begin
      $display("FAIL wrap_next: got %h want 0", imem_addr);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, w, mpc, rs;
    bit ok, j, r, b, t, bad;
    int ns;
    do_reset();
    mpc = RST_PC;
    for (int it = 0; it < 40; it++) begin
      w = $urandom;
      do_fetch($urandom_range(0, 3), w, a, ok);
      n_chk++;
      if (!ok || a !== mpc) begin
        $display("FAIL rnd_addr[%0d]: got %h want %h", it, a, mpc);
      end else n_pass++;
      n_chk++;
      if (inst !== w || pc !== mpc || pc_plus4 !== mpc + 32'd4 ||
          inst_valid !== 1'b1) begin
        $display("FAIL rnd_hold[%0d]: inst=%h pc=%h want %h %h",
                 it, inst, pc, w, mpc);
      end else n_pass++;
      ns = $urandom_range(0, 2);
      bad = 1'b0;
      for (int s = 0; s < ns; s++) begin
        {jump, jr, branch, br_taken, halt} = 5'($urandom);
        @(negedge clk);
        if (inst !== w || pc !== mpc || inst_valid !== 1'b1) bad = 1'b1;
      end
      n_chk++;
      if (bad) begin
        $display("FAIL rnd_stall[%0d]: inst=%h pc=%h", it, inst, pc);
      end else n_pass++;
      j = 1'($urandom);
      b = 1'($urandom);
      t = 1'($urandom);
      r = ($urandom_range(0, 3) == 0);
      rs = $urandom & 32'hFFFF_FFFC;
      mpc = model_npc(mpc, w, j, r, b, t, rs);
      do_accept(j, r, b, t, 0, rs);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== mpc) begin
        $display("FAIL rnd_next[%0d]: req=%b addr=%h want 1 %h",
                 it, imem_req, imem_addr, mpc);
      end else n_pass++;
    end
  endtask

  task automatic test_addr_err();
    logic [31:0] a;
    bit ok, bad;
    do_reset();
    do_fetch(0, $urandom, a, ok);
    do_accept(0, 1, 0, 0, 0, 32'h0040_0002);
    n_chk++;
    if (halted !== 1'b1 || addr_err !== 1'b1 || imem_req !== 1'b0) begin
      $display("FAIL addr_err: hlt=%b err=%b req=%b want 1 1 0",
               halted, addr_err, imem_req);
    end else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'($urandom);
      inst_ready = 1'($urandom);
      @(negedge clk);
      if (halted !== 1'b1 || addr_err !== 1'b1 || imem_req !== 1'b0 ||
          inst_valid !== 1'b0) bad = 1'b1;
    end
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    n_chk++;
    if (bad) begin
      $display("FAIL addr_err_sticky: hlt=%b err=%b req=%b", halted,
               addr_err, imem_req);
    end else n_pass++;
  endtask

  task automatic test_halt();
    logic [31:0] a;
    bit ok, bad;
    do_reset();
    do_fetch(0, 32'h0000_000C, a, ok);
    do_accept(1, 1, 0, 0, 1, 32'h0040_0003);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'($urandom);
      @(negedge clk);
      if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0)
        bad = 1'b1;
    end
    imem_ack = 1'b0;
    n_chk++;
    if (!ok || bad || addr_err !== 1'b0) begin
      $display("FAIL halt: hlt=%b err=%b req=%b want 1 0 0",
               halted, addr_err, imem_req);
    end else n_pass++;
  endtask

  task automatic test_reset_hold();
    logic [31:0] a;
    bit ok;
    do_reset();
    go_to(32'h0040_0100);
    do_fetch(0, $urandom, a, ok);
    n_chk++;
    if (!ok || inst_valid !== 1'b1 || pc !== 32'h0040_0100) begin
      $display("FAIL rst_hold_setup: v=%b pc=%h want 1 00400100",
               inst_valid, pc);
    end else n_pass++;
    rst_b = 1'b0;
    #1;
    n_chk++;
    if (inst_valid !== 1'b0 || pc !== RST_PC || imem_req !== 1'b0) begin
      $display("FAIL rst_hold_async: v=%b pc=%h req=%b want 0 %h 0",
               inst_valid, pc, imem_req, RST_PC);
    end else n_pass++;
    @(negedge clk);
    rst_b = 1'b1;
    do_fetch(0, $urandom, a, ok);
    n_chk++;
    if (!ok || a !== RST_PC) begin
      $display("FAIL rst_hold_refetch: got %h want %h", a, RST_PC);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_random();
    test_addr_err();
    test_halt();
    test_reset_hold();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
